axi_raddr_chs: RTL

Read-address channel stage of the AXI MMU wrapper, directly upstream of the read-data stage. It accepts one AR request at a time from the application/interconnect and sends the virtual address to the MMU translation port. A permitted request is forwarded to the memory controller with the physical address. A faulting request is turned into a drop command for the read-data stage, which then synthesises SLVERR beats. Drops are held back until every forwarded burst has returned its last beat, so error beats never interleave with real read data.

---
 rtl/axi_mmu_pkg.sv | 33 +++
 rtl/axi_outs_ctr.sv | 34 +++
 rtl/axi_raddr_chs.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axi_mmu_pkg.sv
// Shared definitions for the AXI MMU wrapper stages: FSM encoding,
// AXI burst/response codes and AR field widths.
package axi_mmu_pkg;

  localparam int AXI_LEN_WID   = 8;
  localparam int AXI_SIZE_WID  = 3;
  localparam int AXI_BURST_WID = 2;
  localparam int AXI_RESP_WID  = 2;

  localparam logic [AXI_BURST_WID-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_WID-1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_WID-1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [AXI_RESP_WID-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_WID-1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [AXI_RESP_WID-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_WID-1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XREQ,
    ST_XWAIT,
    ST_ISSUE,
    ST_DRAIN,
    ST_DROP
  } ar_state_e;

  // Beat count of a burst; 256 beats does not fit in 8 bits, so it saturates.
  function automatic logic [AXI_LEN_WID-1:0] len_to_beats(input logic [AXI_LEN_WID-1:0] len);
    return (len == 8'hFF) ? 8'hFF : len + 8'd1;
  endfunction

endpackage

// File: rtl/axi_outs_ctr.sv
// Saturating up/down counter of in-flight bursts. The full and zero flags
// look ahead: they describe the value the counter holds after this edge.
module axi_outs_ctr #(
  parameter int WID = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero
);

  localparam logic [WID-1:0] MAX = '1;

  logic [WID-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q != MAX)
      count_d = count_q + WID'(1);
    else if (dec && !inc && count_q != '0)
      count_d = count_q - WID'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign full = (count_d == MAX);
  assign zero = (count_d == '0);

endmodule

// File: rtl/axi_raddr_chs.sv
// Read-address channel stage: translates each AR request through the MMU,
// forwards permitted bursts and turns faults into drop commands.
module axi_raddr_chs
  import axi_mmu_pkg::*;
#(
  parameter int ID_WID   = 8,
  parameter int ADDR_WID = 32,
  parameter int USER_WID = 2,
  parameter int OUTS_WID = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ID_WID-1:0]        in_arid,
  input  logic [ADDR_WID-1:0]      in_araddr,
  input  logic [AXI_LEN_WID-1:0]   in_arlen,
  input  logic [AXI_SIZE_WID-1:0]  in_arsize,
  input  logic [AXI_BURST_WID-1:0] in_arburst,
  input  logic [USER_WID-1:0]      in_aruser,
  input  logic                     in_sarvalid,
  output logic                     out_sarready,
  output logic                     out_xlat_valid,
  output logic [ADDR_WID-1:0]      out_xlat_vaddr,
  input  logic                     in_xlat_ready,
  input  logic                     in_xlat_rvalid,
  input  logic [ADDR_WID-1:0]      in_xlat_paddr,
  input  logic                     in_xlat_ok,
  output logic [ID_WID-1:0]        out_arid,
  output logic [ADDR_WID-1:0]      out_araddr,
  output logic [AXI_LEN_WID-1:0]   out_arlen,
  output logic [AXI_SIZE_WID-1:0]  out_arsize,
  output logic [AXI_BURST_WID-1:0] out_arburst,
  output logic [USER_WID-1:0]      out_aruser,
  output logic                     out_marvalid,
  input  logic                     in_marready,
  input  logic                     in_rlast_hs,
  output logic                     drop,
  output logic [ID_WID-1:0]        drop_arid,
  output logic [USER_WID-1:0]      drop_aruser,
  output logic [AXI_SIZE_WID-1:0]  drop_arsize,
  output logic [AXI_LEN_WID-1:0]   drop_arlen,
  input  logic                     in_drop_done,
  output logic                     err_sat
);

  ar_state_e state_q, state_d;

  logic [ID_WID-1:0]        arid_q, arid_d;
  logic [ADDR_WID-1:0]      vaddr_q, vaddr_d;
  logic [ADDR_WID-1:0]      paddr_q, paddr_d;
  logic [AXI_LEN_WID-1:0]   arlen_q, arlen_d;
  logic [AXI_SIZE_WID-1:0]  arsize_q, arsize_d;
  logic [AXI_BURST_WID-1:0] arburst_q, arburst_d;
  logic [USER_WID-1:0]      aruser_q, aruser_d;

  logic sarready_q, sarready_d;
  logic xlat_valid_q, xlat_valid_d;
  logic marvalid_q, marvalid_d;
  logic drop_q, drop_d;
  logic err_sat_q, err_sat_d;

  logic [ID_WID-1:0]       drop_arid_q, drop_arid_d;
  logic [USER_WID-1:0]     drop_aruser_q, drop_aruser_d;
  logic [AXI_SIZE_WID-1:0] drop_arsize_q, drop_arsize_d;
  logic [AXI_LEN_WID-1:0]  drop_arlen_q, drop_arlen_d;

  logic outs_inc, outs_full, outs_zero;

  assign outs_inc = marvalid_q & in_marready;

  axi_outs_ctr #(.WID(OUTS_WID)) u_outs (
    .clk   (clk),
    .reset (reset),
    .inc   (outs_inc),
    .dec   (in_rlast_hs),
    .full  (outs_full),
    .zero  (outs_zero)
  );

  always_comb begin
    state_d       = state_q;
    arid_d        = arid_q;
    vaddr_d       = vaddr_q;
    paddr_d       = paddr_q;
    arlen_d       = arlen_q;
    arsize_d      = arsize_q;
    arburst_d     = arburst_q;
    aruser_d      = aruser_q;
    drop_d        = 1'b0;
    err_sat_d     = err_sat_q;
    drop_arid_d   = drop_arid_q;
    drop_aruser_d = drop_aruser_q;
    drop_arsize_d = drop_arsize_q;
    drop_arlen_d  = drop_arlen_q;

    case (state_q)
      ST_IDLE: if (in_sarvalid) begin
        arid_d    = in_arid;
        vaddr_d   = in_araddr;
        arlen_d   = in_arlen;
        arsize_d  = in_arsize;
        arburst_d = in_arburst;
        aruser_d  = in_aruser;
        state_d   = ST_XREQ;
      end
      ST_XREQ: if (in_xlat_ready) state_d = ST_XWAIT;
      ST_XWAIT: if (in_xlat_rvalid) begin
        if (in_xlat_ok) begin
          paddr_d = in_xlat_paddr;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_ISSUE: if (outs_inc) state_d = ST_IDLE;
      // Zero flag is look-ahead, so the drop lands the cycle after the last rlast.
      ST_DRAIN: if (outs_zero) begin
        drop_d        = 1'b1;
        drop_arid_d   = arid_q;
        drop_aruser_d = aruser_q;
        drop_arsize_d = arsize_q;
        drop_arlen_d  = len_to_beats(arlen_q);
        if (arlen_q == 8'hFF) err_sat_d = 1'b1;
        state_d = ST_DROP;
      end
      ST_DROP: if (in_drop_done && !drop_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    sarready_d   = (state_d == ST_IDLE);
    xlat_valid_d = (state_d == ST_XREQ);
    marvalid_d   = (state_d == ST_ISSUE) && !outs_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      arid_q        <= '0;
      vaddr_q       <= '0;
      paddr_q       <= '0;
      arlen_q       <= '0;
      arsize_q      <= '0;
      arburst_q     <= '0;
      aruser_q      <= '0;
      sarready_q    <= 1'b1;
      xlat_valid_q  <= 1'b0;
      marvalid_q    <= 1'b0;
      drop_q        <= 1'b0;
      err_sat_q     <= 1'b0;
      drop_arid_q   <= '0;
      drop_aruser_q <= '0;
      drop_arsize_q <= '0;
      drop_arlen_q  <= '0;
    end else begin
      state_q       <= state_d;
      arid_q        <= arid_d;
      vaddr_q       <= vaddr_d;
      paddr_q       <= paddr_d;
      arlen_q       <= arlen_d;
      arsize_q      <= arsize_d;
      arburst_q     <= arburst_d;
      aruser_q      <= aruser_d;
      sarready_q    <= sarready_d;
      xlat_valid_q  <= xlat_valid_d;
      marvalid_q    <= marvalid_d;
      drop_q        <= drop_d;
      err_sat_q     <= err_sat_d;
      drop_arid_q   <= drop_arid_d;
      drop_aruser_q <= drop_aruser_d;
      drop_arsize_q <= drop_arsize_d;
      drop_arlen_q  <= drop_arlen_d;
    end
  end

  assign out_sarready   = sarready_q;
  assign out_xlat_valid = xlat_valid_q;
  assign out_xlat_vaddr = vaddr_q;
  assign out_arid       = arid_q;
  assign out_araddr     = paddr_q;
  assign out_arlen      = arlen_q;
  assign out_arsize     = arsize_q;
  assign out_arburst    = arburst_q;
  assign out_aruser     = aruser_q;
  assign out_marvalid   = marvalid_q;
  assign drop           = drop_q;
  assign drop_arid      = drop_arid_q;
  assign drop_aruser    = drop_aruser_q;
  assign drop_arsize    = drop_arsize_q;
  assign drop_arlen     = drop_arlen_q;
  assign err_sat        = err_sat_q;

endmodule
